// File: rtl/mac_learner_pkg.sv
// mac_learner_pkg: parser state encoding and frame constants shared by mac_learner and crc32_d8.
package mac_learner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_BODY,
    ST_DROP
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam int          HDR_LEN       = 14;

  localparam int              CNT_W    = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] SA_FIRST = 11'd6;
  localparam logic [CNT_W-1:0] SA_LAST  = 11'd11;
  localparam logic [CNT_W-1:0] HDR_LAST = 11'(HDR_LEN - 1);

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide reflected CRC-32; init loads all-ones, en folds in one byte LSB first.
module crc32_d8
  import mac_learner_pkg::*;
(
  input  logic        clk,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REFL = bit_rev32(CRC32_POLY);

  logic [31:0] crc_nxt;

  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 8; i++)
      crc_nxt = (crc_nxt[0] ^ data[i]) ? ((crc_nxt >> 1) ^ POLY_REFL) : (crc_nxt >> 1);
  end

  always_ff @(posedge clk) begin
    if (init)    crc <= '1;
    else if (en) crc <= crc_nxt;
  end

endmodule

// File: rtl/mac_learner.sv
// mac_learner: forwards the GMII transmit stream with one cycle of delay and learns the frame source MAC.
// Define MAC_LEARNER_FCS_CHECK_EN to also require a good CRC-32 FCS and an 18-byte minimum frame.
module mac_learner
  import mac_learner_pkg::*;
#(
  parameter logic [7:0] SFD        = 8'hD5,
  parameter int         MIN_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mac_clear,
  input  logic [7:0]  up_data,
  input  logic        up_dv,
  input  logic        up_er,
  output logic [7:0]  down_data,
  output logic        down_dv,
  output logic        down_er,
  output logic [47:0] mac_address,
  output logic        mac_valid,
  output logic        mac_changed
);

  localparam logic [3:0] MIN_CNT = 4'(MIN_FRAMES);

  state_t             state, state_nxt;
  logic               frame_end;
  logic [CNT_W-1:0]   byte_cnt;
  logic [47:0]        sa_sr;
  logic [47:0]        cand;
  logic [3:0]         agree;
  logic               pend_p1;
  logic               sa_ok, len_ok, fcs_ok, accept;

  // stage p0 -> p1: unconditional forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_data <= '0;
      down_dv   <= 1'b0;
      down_er   <= 1'b0;
    end else begin
      down_data <= up_data;
      down_dv   <= up_dv;
      down_er   <= up_er;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    if (up_dv && up_er) begin
      state_nxt = ST_DROP;
    end else begin
      case (state)
        ST_IDLE: if (up_dv) state_nxt = (up_data == PREAMBLE_BYTE) ? ST_PRE : ST_DROP;
        ST_PRE: begin
          if (!up_dv)                        state_nxt = ST_IDLE;
          else if (up_data == PREAMBLE_BYTE) state_nxt = ST_PRE;
          else if (up_data == SFD)           state_nxt = ST_HDR;
          else                               state_nxt = ST_DROP;
        end
        ST_HDR: begin
          if (!up_dv)                    state_nxt = ST_IDLE;
          else if (byte_cnt == HDR_LAST) state_nxt = ST_BODY;
        end
        ST_BODY: if (!up_dv) begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_DROP: if (!up_dv) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counter and SA register are datapath: the SFD always re-arms them before use.
  always_ff @(posedge clk) begin
    if (state == ST_PRE && up_dv && up_data == SFD)
      byte_cnt <= '0;
    else if (up_dv && (state == ST_HDR || state == ST_BODY) && byte_cnt != CNT_MAX)
      byte_cnt <= byte_cnt + 1'b1;
    if (state == ST_HDR && up_dv && byte_cnt >= SA_FIRST && byte_cnt <= SA_LAST)
      sa_sr <= {sa_sr[39:0], up_data};
  end

`ifdef MAC_LEARNER_FCS_CHECK_EN
  localparam logic [CNT_W-1:0] MIN_LEN = 11'd18;
  localparam logic [31:0]      RESIDUE_REFL = bit_rev32(CRC32_RESIDUE);

  logic [31:0] crc;
  logic        crc_init, crc_en;

  assign crc_init = (state == ST_PRE) && up_dv && (up_data == SFD);
  assign crc_en   = up_dv && (state == ST_HDR || state == ST_BODY);

  crc32_d8 u_crc (
    .clk  (clk),
    .init (crc_init),
    .en   (crc_en),
    .data (up_data),
    .crc  (crc)
  );

  assign fcs_ok = (crc == RESIDUE_REFL);
`else
  localparam logic [CNT_W-1:0] MIN_LEN = 11'd15;

  assign fcs_ok = 1'b1;
`endif

  assign sa_ok  = !sa_sr[40] && (sa_sr != '0);
  assign len_ok = (byte_cnt >= MIN_LEN);
  assign accept = frame_end && sa_ok && len_ok && fcs_ok;

  // stage p1: candidate tracking on frame end, publication one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= '0;
      agree       <= '0;
      pend_p1     <= 1'b0;
      mac_address <= '0;
      mac_valid   <= 1'b0;
      mac_changed <= 1'b0;
    end else begin
      mac_changed <= 1'b0;
      if (mac_clear) begin
        cand      <= '0;
        agree     <= '0;
        pend_p1   <= 1'b0;
        mac_valid <= 1'b0;
      end else begin
        pend_p1 <= accept;
        if (accept) begin
          if (sa_sr == cand) begin
            if (agree != MIN_CNT) agree <= agree + 4'd1;
          end else begin
            cand  <= sa_sr;
            agree <= 4'd1;
          end
        end
        if (pend_p1 && agree == MIN_CNT && (!mac_valid || cand != mac_address)) begin
          mac_address <= cand;
          mac_valid   <= 1'b1;
          mac_changed <= mac_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_learner.sv
// tb_mac_learner: directed and randomized frames against a frame-level learning model and a 1-cycle forwarding model.
`timescale 1ns/1ps
module tb_mac_learner;

  localparam int MIN_FRAMES = 2;
`ifdef MAC_LEARNER_FCS_CHECK_EN
  localparam int MIN_LEN = 18;
  localparam bit FCS_EN  = 1'b1;
`else
  localparam int MIN_LEN = 15;
  localparam bit FCS_EN  = 1'b0;
`endif

  localparam logic [47:0] SA_A = 48'h112233AABBCC;
  localparam logic [47:0] SA_B = 48'h020000000005;
  localparam logic [47:0] SA_M = 48'h01005E000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mac_clear = 1'b0;
  logic [7:0]  up_data = '0;
  logic        up_dv = 1'b0;
  logic        up_er = 1'b0;
  logic [7:0]  down_data;
  logic        down_dv, down_er;
  logic [47:0] mac_address;
  logic        mac_valid, mac_changed;

  always #5 clk = ~clk;

  mac_learner #(.SFD(8'hD5), .MIN_FRAMES(MIN_FRAMES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mac_clear   (mac_clear),
    .up_data     (up_data),
    .up_dv       (up_dv),
    .up_er       (up_er),
    .down_data   (down_data),
    .down_dv     (down_dv),
    .down_er     (down_er),
    .mac_address (mac_address),
    .mac_valid   (mac_valid),
    .mac_changed (mac_changed)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Forwarding reference: whatever was on up_* at the last edge
  logic [9:0] cap_fwd = '0;
  logic       cap_rst = 1'b0;
  always @(posedge clk) begin
    cap_fwd <= {up_er, up_dv, up_data};
    cap_rst <= rst_n;
  end

  // Scheduled changes of the published address, keyed by cycle
  typedef struct {
    int          cyc;
    logic        v;
    logic [47:0] a;
    logic        chg;
  } ev_t;
  ev_t evq[$];

  logic        pub_v = 1'b0;
  logic [47:0] pub_a = '0;
  logic        exp_chg;

  initial forever begin
    @(negedge clk);
    exp_chg = 1'b0;
    if (!rst_n) begin
      pub_v = 1'b0;
      pub_a = '0;
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        pub_v   = evq[0].v;
        pub_a   = evq[0].a;
        exp_chg = evq[0].chg;
        void'(evq.pop_front());
      end
    end
    check("fwd", {down_er, down_dv, down_data}, (rst_n && cap_rst) ? cap_fwd : 10'h0);
    check("mac_valid", mac_valid, pub_v);
    check("mac_address", mac_address, pub_a);
    check("mac_changed", mac_changed, exp_chg);
  end

  // Frame-level learning model
  logic        m_v = 1'b0;
  logic [47:0] m_a = '0;
  logic [47:0] m_cand = '0;
  int          m_cnt = 0;

  task automatic push_ev(input int c, input logic v, input logic [47:0] a, input logic chg);
    ev_t e;
    e.cyc = c; e.v = v; e.a = a; e.chg = chg;
    evq.push_back(e);
  endtask

  task automatic model_frame(input bit acc, input logic [47:0] sa, input int ev_cyc);
    if (!acc) return;
    if (sa == m_cand) begin
      if (m_cnt < MIN_FRAMES) m_cnt++;
    end else begin
      m_cand = sa;
      m_cnt  = 1;
    end
    if (m_cnt == MIN_FRAMES && (!m_v || m_cand != m_a)) begin
      push_ev(ev_cyc, 1'b1, m_cand, m_v);
      m_v = 1'b1;
      m_a = m_cand;
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_a = '0; m_cand = '0; m_cnt = 0;
  endtask

  function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Inputs change 1 time unit after the active edge
  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    up_dv = dv; up_data = d; up_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_clear();
    idle(1);
    mac_clear = 1'b1;
    m_v = 1'b0; m_cnt = 0; m_cand = '0;
    push_ev(cyc + 1, 1'b0, m_a, 1'b0);
    idle(1);
    mac_clear = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] sa, input int len, input int pre_len, input bit bad_pre,
                            input int er_idx, input int rst_idx, input bit flip_fcs, input int gap,
                            input bit clr_end);
    logic [7:0]  b[$];
    logic [7:0]  x;
    logic [31:0] fcs;
    bit          acc;
    int          last;
    last = 0;
    for (int i = 0; i < len; i++) begin
      if (i >= 6 && i < 12) x = sa[8*(11-i) +: 8];
      else begin
        x = 8'($urandom);
        if (x == 8'h55) x = 8'h56;
      end
      b.push_back(x);
    end
    if (len >= 15) begin
      fcs = fcs_of(b, len - 4);
      if (flip_fcs) fcs[13] = ~fcs[13];
      for (int k = 0; k < 4; k++) b[len-4+k] = fcs[8*k +: 8];
    end
    acc = !bad_pre && er_idx < 0 && rst_idx < 0 && len >= MIN_LEN && !sa[40] && sa != '0
          && !(FCS_EN && flip_fcs);
    for (int i = 0; i < pre_len; i++)
      drive(1'b1, (bad_pre && i == pre_len - 2) ? 8'h54 : 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == rst_idx) begin
        rst_n = 1'b0;
        model_reset();
      end
      if (rst_idx >= 0 && i == rst_idx + 2) rst_n = 1'b1;
      if (i == len - 1) last = cyc;
      drive(1'b1, b[i], logic'(i == er_idx));
    end
    rst_n = 1'b1;
    if (clr_end) begin
      m_v = 1'b0; m_cnt = 0; m_cand = '0;
      push_ev(last + 2, 1'b0, m_a, 1'b0);
    end else begin
      model_frame(acc, sa, last + 3);
    end
    for (int g = 0; g < gap; g++) begin
      if (g == 0 && clr_end) mac_clear = 1'b1;
      drive(1'b0, 8'($urandom), 1'($urandom));
      mac_clear = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Two clean frames publish A without a change pulse
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 4, 0);
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 4, 0);
    idle(3);

    // Errored frame does not count; a third clean one does
    do_clear();
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 3, 0);
    send_frame(SA_A, 60, 7, 0,  8, -1, 0, 3, 0);
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 3, 0);

    // Multicast never learns
    do_clear();
    for (int i = 0; i < 10; i++) send_frame(SA_M, 60, 7, 0, -1, -1, 0, 2, 0);
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 2, 0);
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 2, 0);

    // Replacement produces one change pulse, then clear
    send_frame(SA_B, 60, 7, 0, -1, -1, 0, 2, 0);
    send_frame(SA_B, 60, 7, 0, -1, -1, 0, 4, 0);
    do_clear();

    // Runt, bad preamble and mid-frame reset do not learn
    send_frame(SA_A, 60, 7, 0, -1, -1, 0, 2, 0);
    send_frame(SA_A, 10, 7, 0, -1, -1, 0, 2, 0);
    send_frame(SA_A, 60, 7, 1, -1, -1, 0, 2, 0);
    send_frame(SA_A, 60, 7, 0, -1, 30, 0, 2, 0);
    send_frame(SA_B, 60, 7, 0, -1, -1, 0, 1, 0);
    send_frame(SA_B, 60, 7, 0, -1, -1, 0, 1, 0);

    // Clear on the evaluation cycle wins over the frame
    send_frame(SA_A, 40, 3, 0, -1, -1, 0, 1, 0);
    send_frame(SA_A, 40, 3, 0, -1, -1, 0, 2, 1);
    send_frame(SA_A, 40, 3, 0, -1, -1, 0, 1, 0);
    send_frame(SA_A, 40, 3, 0, -1, -1, 0, 3, 0);

`ifdef MAC_LEARNER_FCS_CHECK_EN
    do_clear();
    send_frame(SA_B, 64, 7, 0, -1, -1, 0, 2, 0);
    send_frame(SA_B, 64, 7, 0, -1, -1, 1, 2, 0);
    send_frame(SA_B, 64, 7, 0, -1, -1, 0, 3, 0);
`endif

    // Randomized traffic with back-to-back frames and mixed faults
    for (int n = 0; n < 60; n++) begin
      logic [47:0] sa;
      int          sel, len, er_idx, pre_len, gap;
      bit          bp, clr;
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1, 2: sa = SA_A;
        3:       sa = SA_B;
        4:       sa = SA_M;
        5:       sa = 48'h0;
        default: sa = 48'({$urandom(), $urandom()}) & 48'hFEFFFFFFFFFF;
      endcase
      len     = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 13) : $urandom_range(15, 70);
      er_idx  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      bp      = ($urandom_range(0, 19) == 0);
      pre_len = $urandom_range(2, 8);
      gap     = $urandom_range(1, 3);
      clr     = ($urandom_range(0, 19) == 0);
      send_frame(sa, len, pre_len, bp, er_idx, -1, 0, gap, clr);
      if ($urandom_range(0, 19) == 0) do_clear();
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
